// File: rtl/linebuf_sched.sv
// linebuf_sched: line-buffer scheduler for the 3x3 median window (rotating write buffer, column addressing, window flags).
// Optional `WIDTH_CHECK_EN` enables a sticky line-length mismatch flag on o_line_err.
module linebuf_sched #(
  parameter int ADDR_W = 11
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vsync,
  input  logic              i_hsync,
  input  logic              i_dv,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [2:0]        o_wr_sel,
  output logic [2:0]        o_mid_sel,
  output logic [2:0]        o_top_sel,
  output logic              o_win_valid,
  output logic              o_first_col,
  output logic              o_last_col,
  output logic [ADDR_W-1:0] o_width,
  output logic              o_line_err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LINE0 = 2'd1;
  localparam logic [1:0] S_LINE1 = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;
  localparam logic [ADDR_W-1:0] MAX = '1;
  localparam logic [ADDR_W-1:0] ONE = 1;
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_width;
  logic [2:0]        r_wr_sel;
  logic              r_win_valid;
  logic              r_first_col;
  logic              r_last_col;
  logic              w_active;
  logic              w_hs;
  logic              w_pix;
  logic              w_run_pix;
  logic [ADDR_W-1:0] w_cnt;
  // vsync wins over hsync and dv; the pixel in a vsync cycle is discarded
  assign w_active  = r_state != S_IDLE;
  assign w_hs      = w_active & i_hsync & ~i_vsync;
  assign w_pix     = w_active & i_dv & ~i_vsync;
  assign w_run_pix = w_pix & (r_state == S_RUN);
  // saturating next column, doubling as the pixel count of the line at hsync
  assign w_cnt     = (w_pix && r_wr_addr != MAX) ? r_wr_addr + ONE : r_wr_addr;
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_wr_addr   <= '0;
      r_wr_sel    <= 3'b001;
      r_width     <= '0;
      r_win_valid <= 1'b0;
      r_first_col <= 1'b0;
      r_last_col  <= 1'b0;
    end else begin
      r_win_valid <= w_run_pix;
      r_first_col <= w_run_pix && r_wr_addr == '0;
      r_last_col  <= w_run_pix && r_width != '0 && r_wr_addr == r_width - ONE;
      if (i_vsync) begin
        r_state   <= S_LINE0;
        r_wr_addr <= '0;
        r_wr_sel  <= 3'b001;
      end else if (w_hs) begin
        r_wr_addr <= '0;
        r_wr_sel  <= {r_wr_sel[1:0], r_wr_sel[2]};
        r_state   <= (r_state == S_LINE0) ? S_LINE1 : S_RUN;
        if (r_state == S_LINE0) r_width <= w_cnt;
      end else if (w_pix) begin
        r_wr_addr <= w_cnt;
      end
    end
  end
`ifdef WIDTH_CHECK_EN
  logic r_line_err;
  always_ff @(posedge i_clk) begin
    if (!i_rst || i_vsync) r_line_err <= 1'b0;
    else if (w_hs && r_state != S_LINE0 && w_cnt != r_width) r_line_err <= 1'b1;
  end
  assign o_line_err = r_line_err;
`else
  assign o_line_err = 1'b0;
`endif
  assign o_wr_addr   = r_wr_addr;
  assign o_rd_addr   = r_wr_addr;
  assign o_wr_sel    = r_wr_sel;
  assign o_mid_sel   = {r_wr_sel[0], r_wr_sel[2:1]};
  assign o_top_sel   = {r_wr_sel[1:0], r_wr_sel[2]};
  assign o_win_valid = r_win_valid;
  assign o_first_col = r_first_col;
  assign o_last_col  = r_last_col;
  assign o_width     = r_width;
endmodule

// File: tb/tb_linebuf_sched.sv
// tb_linebuf_sched: directed self-checking bench for linebuf_sched (default width and a 3-bit narrow instance).
module tb_linebuf_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vs = 1'b0, hs = 1'b0, dv = 1'b0;
  logic [10:0] wr_addr, rd_addr, width;
  logic [2:0]  wr_sel, mid_sel, top_sel;
  logic        wv, fc, lc, lerr;
  logic [2:0]  s_wr_addr, s_rd_addr, s_width;
  logic [2:0]  s_wr_sel, s_mid_sel, s_top_sel;
  logic        s_wv, s_fc, s_lc, s_lerr;
  int checks = 0;
  int errors = 0;
  logic exp_err;

  always #5 clk = ~clk;

  linebuf_sched dut (
    .i_clk(clk), .i_rst(rst), .i_vsync(vs), .i_hsync(hs), .i_dv(dv),
    .o_wr_addr(wr_addr), .o_rd_addr(rd_addr), .o_wr_sel(wr_sel), .o_mid_sel(mid_sel),
    .o_top_sel(top_sel), .o_win_valid(wv), .o_first_col(fc), .o_last_col(lc),
    .o_width(width), .o_line_err(lerr)
  );

  linebuf_sched #(.ADDR_W(3)) dut_small (
    .i_clk(clk), .i_rst(rst), .i_vsync(vs), .i_hsync(hs), .i_dv(dv),
    .o_wr_addr(s_wr_addr), .o_rd_addr(s_rd_addr), .o_wr_sel(s_wr_sel), .o_mid_sel(s_mid_sel),
    .o_top_sel(s_top_sel), .o_win_valid(s_wv), .o_first_col(s_fc), .o_last_col(s_lc),
    .o_width(s_width), .o_line_err(s_lerr)
  );

  task automatic step(input logic v, input logic h, input logic d);
    vs = v; hs = h; dv = d;
    @(posedge clk);
    #1;
    vs = 1'b0; hs = 1'b0; dv = 1'b0;
  endtask

  task automatic line(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    checks++; if ({wr_addr, width} !== 22'd0) begin errors++; $display("FAIL reset_addr_width: got %0h/%0h exp 0/0", wr_addr, width); end
    checks++; if (wr_sel !== 3'b001) begin errors++; $display("FAIL reset_wr_sel: got %b exp 001", wr_sel); end
    checks++; if ({wv, fc, lc, lerr} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {wv, fc, lc, lerr}); end
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    checks++; if ({wr_addr, wr_sel} !== {11'd0, 3'b001}) begin errors++; $display("FAIL idle_ignores: got %0h/%b exp 0/001", wr_addr, wr_sel); end
  endtask

  task automatic test_line0;
    logic seen;
    seen = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin step(1'b0, 1'b0, 1'b1); seen |= wv; end
    checks++; if (wr_addr !== 11'd4) begin errors++; $display("FAIL line0_addr: got %0d exp 4", wr_addr); end
    step(1'b0, 1'b1, 1'b0);
    seen |= wv;
    checks++; if (width !== 11'd4) begin errors++; $display("FAIL line0_width: got %0d exp 4", width); end
    checks++; if ({wr_sel, wr_addr} !== {3'b010, 11'd0}) begin errors++; $display("FAIL line0_sel: got %b/%0d exp 010/0", wr_sel, wr_addr); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL line0_no_wv: got %b exp 0", seen); end
  endtask

  task automatic test_window;
    logic seen;
    step(1'b1, 1'b0, 1'b0);
    line(4);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin step(1'b0, 1'b0, 1'b1); seen |= wv; end
    step(1'b0, 1'b1, 1'b0);
    seen |= wv;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL line1_no_wv: got %b exp 0", seen); end
    checks++; if ({wr_sel, mid_sel, top_sel} !== 9'b100_010_001) begin errors++; $display("FAIL run_sels: got %b/%b/%b exp 100/010/001", wr_sel, mid_sel, top_sel); end
    checks++; if (rd_addr !== 11'd0) begin errors++; $display("FAIL run_rd_addr0: got %0d exp 0", rd_addr); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1);
      checks++; if ({wv, fc, lc} !== {1'b1, i == 0, i == 3}) begin errors++; $display("FAIL run_col%0d: got wv/fc/lc=%b exp %b", i, {wv, fc, lc}, {1'b1, i == 0, i == 3}); end
      checks++; if (rd_addr !== 11'(i + 1)) begin errors++; $display("FAIL run_rd_addr%0d: got %0d exp %0d", i, rd_addr, i + 1); end
    end
    step(1'b0, 1'b0, 1'b0);
    checks++; if ({wv, fc, lc} !== 3'b000) begin errors++; $display("FAIL run_gap: got %b exp 000", {wv, fc, lc}); end
    step(1'b0, 1'b1, 1'b0);
    checks++; if ({wr_sel, mid_sel, top_sel} !== 9'b001_100_010) begin errors++; $display("FAIL run_rotate: got %b/%b/%b exp 001/100/010", wr_sel, mid_sel, top_sel); end
  endtask

  task automatic test_coincident;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    checks++; if ({width, wr_addr} !== {11'd5, 11'd0}) begin errors++; $display("FAIL dv_hsync: got width=%0d addr=%0d exp 5/0", width, wr_addr); end
  endtask

  task automatic test_vsync;
    line(5);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    checks++; if ({wr_addr, wv} !== {11'd2, 1'b1}) begin errors++; $display("FAIL pre_vsync: got addr=%0d wv=%b exp 2/1", wr_addr, wv); end
    step(1'b1, 1'b0, 1'b1);
    checks++; if ({wr_addr, wr_sel, wv} !== {11'd0, 3'b001, 1'b0}) begin errors++; $display("FAIL vsync_run: got %0d/%b/%b exp 0/001/0", wr_addr, wr_sel, wv); end
    checks++; if (width !== 11'd5) begin errors++; $display("FAIL vsync_width: got %0d exp 5", width); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    checks++; if ({width, wr_sel, wr_addr} !== {11'd5, 3'b001, 11'd0}) begin errors++; $display("FAIL vsync_beats_hsync: got %0d/%b/%0d exp 5/001/0", width, wr_sel, wr_addr); end
  endtask

  task automatic test_saturate;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
    checks++; if (s_wr_addr !== 3'd7) begin errors++; $display("FAIL sat_small: got %0d exp 7", s_wr_addr); end
    checks++; if (wr_addr !== 11'd10) begin errors++; $display("FAIL sat_big: got %0d exp 10", wr_addr); end
    step(1'b0, 1'b1, 1'b0);
    checks++; if ({s_wr_addr, wr_addr} !== 14'd0) begin errors++; $display("FAIL sat_hsync: got %0d/%0d exp 0/0", s_wr_addr, wr_addr); end
  endtask

  task automatic test_line_err;
`ifdef WIDTH_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    step(1'b1, 1'b0, 1'b0);
    line(4);
    line(4);
    checks++; if (lerr !== 1'b0) begin errors++; $display("FAIL err_good_lines: got %b exp 0", lerr); end
    line(3);
    checks++; if (lerr !== exp_err) begin errors++; $display("FAIL err_short: got %b exp %b", lerr, exp_err); end
    line(4);
    checks++; if (lerr !== exp_err) begin errors++; $display("FAIL err_sticky: got %b exp %b", lerr, exp_err); end
    step(1'b1, 1'b0, 1'b0);
    checks++; if (lerr !== 1'b0) begin errors++; $display("FAIL err_vsync_clr: got %b exp 0", lerr); end
  endtask

  task automatic test_reset_mid;
    line(4);
    step(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    checks++; if ({width, wr_addr, wr_sel} !== {22'd0, 3'b001}) begin errors++; $display("FAIL reset_mid: got %0d/%0d/%b exp 0/0/001", width, wr_addr, wr_sel); end
  endtask

  initial begin
    test_reset;
    test_line0;
    test_window;
    test_coincident;
    test_vsync;
    test_saturate;
    test_line_err;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
